// File: rtl/leaf_tx_packetizer_pkg.sv
//------------------------------------------------------------------------------
// leaf_pkt_pkg
// Shared BFT leaf packet layout, control port ids and TX state encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package leaf_pkt_pkg;

  localparam int DEF_PAYLOAD_BITS          = 32;
  localparam int DEF_NUM_LEAF_BITS         = 5;
  localparam int DEF_NUM_PORT_BITS         = 4;
  localparam int DEF_NUM_ADDR_BITS         = 7;
  localparam int DEF_NUM_BRAM_ADDR_BITS    = 7;
  localparam int DEF_PACKET_BITS           = 1 + DEF_NUM_LEAF_BITS + DEF_NUM_PORT_BITS
                                           + DEF_NUM_ADDR_BITS + DEF_PAYLOAD_BITS;
  localparam int DEF_CREDIT_BITS           = DEF_NUM_BRAM_ADDR_BITS + 1;
  localparam int DEF_FREESPACE_UPDATE_SIZE = 64;

  localparam int VALID_BIT = DEF_PACKET_BITS - 1;
  localparam int LEAF_MSB  = VALID_BIT - 1;
  localparam int LEAF_LSB  = LEAF_MSB - DEF_NUM_LEAF_BITS + 1;
  localparam int PORT_MSB  = LEAF_LSB - 1;
  localparam int PORT_LSB  = PORT_MSB - DEF_NUM_PORT_BITS + 1;
  localparam int ADDR_MSB  = PORT_LSB - 1;
  localparam int ADDR_LSB  = ADDR_MSB - DEF_NUM_ADDR_BITS + 1;

  localparam int DEF_CTRL_PORT_CREDIT = 0;
  localparam int DEF_CTRL_PORT_CFG    = 1;

  typedef enum logic [0:0] {
    UNCFG  = 1'b0,
    ACTIVE = 1'b1
  } tx_state_e;

endpackage : leaf_pkt_pkg

`default_nettype wire

// File: rtl/leaf_tx_packetizer_if.sv
//------------------------------------------------------------------------------
// leaf_tx_packetizer_if
// User word handshake, control packet input and BFT packet output of one leaf TX port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface leaf_tx_packetizer_if
  import leaf_pkt_pkg::*;
#(
  parameter int PACKET_BITS  = DEF_PACKET_BITS,
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int CREDIT_BITS  = DEF_CREDIT_BITS
);

  logic [PAYLOAD_BITS-1:0] din_user;
  logic                    vld_user;
  logic                    ack_user;
  logic [PACKET_BITS-1:0]  din_ctrl;
  logic [PACKET_BITS-1:0]  dout_bft;
  logic                    resend;
  logic                    configured;
  logic [CREDIT_BITS-1:0]  credit;

  modport slave (
    input  din_user, vld_user, din_ctrl, resend,
    output ack_user, dout_bft, configured, credit
  );

  modport master (
    output din_user, vld_user, din_ctrl, resend,
    input  ack_user, dout_bft, configured, credit
  );

endinterface : leaf_tx_packetizer_if

`default_nettype wire

// File: rtl/leaf_tx_packetizer_credit.sv
//------------------------------------------------------------------------------
// leaf_credit_counter
// Free-space credit for the remote input BRAM: add/sub, saturation, sticky overflow.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module leaf_credit_counter #(
  parameter int CREDIT_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_i,
  input  logic                   dec_i,
  input  logic                   add_i,
  input  logic [CREDIT_BITS-1:0] add_n_i,
  output logic [CREDIT_BITS-1:0] credit_o,
  output logic                   overflow_o
);

  localparam logic [CREDIT_BITS:0] CREDIT_MAX = (CREDIT_BITS + 1)'(1) << (CREDIT_BITS - 1);

  logic [CREDIT_BITS-1:0] credit_q, credit_d;
  logic                   overflow_q, overflow_d;
  logic [CREDIT_BITS:0]   sum;

  // One extra bit of headroom so a large return cannot wrap before saturation.
  always_comb begin
    sum        = {1'b0, credit_q};
    credit_d   = credit_q;
    overflow_d = overflow_q;
    if (dec_i) begin
      sum = sum - (CREDIT_BITS + 1)'(1);
    end
    if (add_i) begin
      sum = sum + {1'b0, add_n_i};
    end
    if (load_i) begin
      credit_d = CREDIT_MAX[CREDIT_BITS-1:0];
    end else if (sum > CREDIT_MAX) begin
      credit_d   = CREDIT_MAX[CREDIT_BITS-1:0];
      overflow_d = 1'b1;
    end else begin
      credit_d = sum[CREDIT_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credit_q   <= CREDIT_MAX[CREDIT_BITS-1:0];
      overflow_q <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  assign credit_o   = credit_q;
  assign overflow_o = overflow_q;

endmodule : leaf_credit_counter

`default_nettype wire

// File: rtl/leaf_tx_packetizer.sv
//------------------------------------------------------------------------------
// leaf_tx_packetizer
// Credit-gated packetizer turning 32-bit user words into 49-bit BFT packets.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module leaf_tx_packetizer
  import leaf_pkt_pkg::*;
#(
  parameter int PACKET_BITS           = DEF_PACKET_BITS,
  parameter int PAYLOAD_BITS          = DEF_PAYLOAD_BITS,
  parameter int NUM_LEAF_BITS         = DEF_NUM_LEAF_BITS,
  parameter int NUM_PORT_BITS         = DEF_NUM_PORT_BITS,
  parameter int NUM_ADDR_BITS         = DEF_NUM_ADDR_BITS,
  parameter int NUM_BRAM_ADDR_BITS    = DEF_NUM_BRAM_ADDR_BITS,
  parameter int FREESPACE_UPDATE_SIZE = DEF_FREESPACE_UPDATE_SIZE,
  parameter int SELF_LEAF             = 0,
  parameter int CTRL_PORT_CREDIT      = DEF_CTRL_PORT_CREDIT,
  parameter int CTRL_PORT_CFG         = DEF_CTRL_PORT_CFG
) (
  input  logic                 clk,
  input  logic                 reset_n,
  leaf_tx_packetizer_if.slave  tx
);

  localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;

  // Field offsets come from leaf_pkt_pkg, so the widths here must agree with it.
  if (PACKET_BITS != 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS ||
      PACKET_BITS != DEF_PACKET_BITS || NUM_LEAF_BITS != DEF_NUM_LEAF_BITS ||
      NUM_PORT_BITS != DEF_NUM_PORT_BITS || NUM_ADDR_BITS != DEF_NUM_ADDR_BITS) begin : g_bad_layout
    $error("leaf_tx_packetizer: packet field widths disagree with leaf_pkt_pkg");
  end

  if (FREESPACE_UPDATE_SIZE < 1 || FREESPACE_UPDATE_SIZE > (1 << NUM_BRAM_ADDR_BITS)) begin : g_bad_freespace
    $error("leaf_tx_packetizer: FREESPACE_UPDATE_SIZE exceeds remote buffer depth");
  end

  tx_state_e                state_q, state_d;
  logic [NUM_LEAF_BITS-1:0] dest_leaf_q, dest_leaf_d;
  logic [NUM_PORT_BITS-1:0] dest_port_q, dest_port_d;
  logic [NUM_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [PACKET_BITS-1:0]   dout_q, dout_d;

  logic [NUM_LEAF_BITS-1:0] ctrl_leaf;
  logic [NUM_PORT_BITS-1:0] ctrl_port;
  logic                     ctrl_hit;
  logic                     cfg_hit;
  logic                     credit_hit;
  logic                     ctrl_unused;
  logic [CREDIT_BITS-1:0]   credit;
  logic                     credit_overflow;
  logic                     ack;
  logic                     xfer;
  logic                     configured;

  assign ctrl_leaf   = tx.din_ctrl[LEAF_MSB:LEAF_LSB];
  assign ctrl_port   = tx.din_ctrl[PORT_MSB:PORT_LSB];
  assign ctrl_hit    = tx.din_ctrl[VALID_BIT] && (ctrl_leaf == NUM_LEAF_BITS'(SELF_LEAF));
  assign cfg_hit     = ctrl_hit && (ctrl_port == NUM_PORT_BITS'(CTRL_PORT_CFG));
  assign credit_hit  = ctrl_hit && (ctrl_port == NUM_PORT_BITS'(CTRL_PORT_CREDIT));
  assign ctrl_unused = ^tx.din_ctrl[ADDR_MSB:NUM_LEAF_BITS+NUM_PORT_BITS];

  leaf_credit_counter #(
    .CREDIT_BITS (CREDIT_BITS)
  ) u_credit (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (cfg_hit),
    .dec_i      (xfer),
    .add_i      (credit_hit),
    .add_n_i    (tx.din_ctrl[NUM_BRAM_ADDR_BITS:0]),
    .credit_o   (credit),
    .overflow_o (credit_overflow)
  );

  always_comb begin
    state_d    = state_q;
    configured = 1'b0;
    ack        = 1'b0;
    case (state_q)
      UNCFG: begin
        if (cfg_hit) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        configured = 1'b1;
        ack        = (credit != '0) && !tx.resend;
      end
      default: state_d = UNCFG;
    endcase
  end

  assign xfer = ack && tx.vld_user;

  // Transfer samples the old destination; a same-cycle config then overrides it.
  always_comb begin
    dest_leaf_d = dest_leaf_q;
    dest_port_d = dest_port_q;
    wr_addr_d   = wr_addr_q;
    dout_d      = dout_q;
    if (!tx.resend) begin
      dout_d = '0;
    end
    if (xfer) begin
      dout_d    = {1'b1, dest_leaf_q, dest_port_q, wr_addr_q, tx.din_user};
      wr_addr_d = wr_addr_q + NUM_ADDR_BITS'(1);
    end
    if (cfg_hit) begin
      dest_leaf_d = tx.din_ctrl[NUM_LEAF_BITS+NUM_PORT_BITS-1:NUM_PORT_BITS];
      dest_port_d = tx.din_ctrl[NUM_PORT_BITS-1:0];
      wr_addr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= UNCFG;
      dest_leaf_q <= '0;
      dest_port_q <= '0;
      wr_addr_q   <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      dest_leaf_q <= dest_leaf_d;
      dest_port_q <= dest_port_d;
      wr_addr_q   <= wr_addr_d;
      dout_q      <= dout_d;
    end
  end

  // The held packet reappears once resend drops.
  assign tx.dout_bft   = tx.resend ? '0 : dout_q;
  assign tx.ack_user   = ack;
  assign tx.configured = configured;
  assign tx.credit     = credit;

endmodule : leaf_tx_packetizer

`default_nettype wire
